// File: rtl/serial_cmp_pkg.sv
// Shared types for the digit-serial comparator: FSM state encoding and the
// per-digit relation, plus helpers that map a state onto the published result.
package serial_cmp_pkg;

  typedef enum logic [2:0] {
    S_EQ,
    S_LT,
    S_GT,
    S_LT_LK,
    S_GT_LK
  } cmp_state_t;

  typedef enum logic [1:0] {
    REL_LT,
    REL_EQ,
    REL_GT
  } cmp_rel_t;

  function automatic logic state_is_lt(input cmp_state_t s);
    return (s == S_LT) || (s == S_LT_LK);
  endfunction

  function automatic logic state_is_gt(input cmp_state_t s);
    return (s == S_GT) || (s == S_GT_LK);
  endfunction

endpackage

// File: rtl/digit_cmp.sv
// Combinational single-digit magnitude compare, unsigned or two's complement.
module digit_cmp
  import serial_cmp_pkg::*;
#(
  parameter int DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] a_dig,
  input  logic [DIGIT_W-1:0] b_dig,
  input  logic               is_signed,
  output cmp_rel_t           rel
);

  always_comb begin
    rel = REL_EQ;
    if (is_signed) begin
      if ($signed(a_dig) < $signed(b_dig))      rel = REL_LT;
      else if ($signed(a_dig) > $signed(b_dig)) rel = REL_GT;
    end else begin
      if (a_dig < b_dig)      rel = REL_LT;
      else if (a_dig > b_dig) rel = REL_GT;
    end
  end

endmodule

// File: rtl/digit_serial_comparator_fsm.sv
// Framed digit-serial magnitude comparator, MSB- or LSB-first per frame.
// Optional two's-complement operands when SERIAL_CMP_SIGNED_EN is defined.
module digit_serial_comparator_fsm
  import serial_cmp_pkg::*;
#(
  parameter int DIGIT_W = 1,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_last,
  input  logic               msb_first,
  input  logic [DIGIT_W-1:0] a_dig,
  input  logic [DIGIT_W-1:0] b_dig,
  output logic               res_valid,
  output logic               a_less_b,
  output logic               a_eq_b,
  output logic               a_greater_b,
  output logic [CNT_W-1:0]   res_digits
);

  cmp_state_t       state_q, state_d, cur_state, step_state;
  logic             open_q, open_d;
  logic             msb_q, msb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             res_valid_q, res_valid_d;
  logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
  logic [CNT_W-1:0] digits_q, digits_d;

  logic     first_beat;
  logic     order_msb;
  logic     is_signed_beat;
  cmp_rel_t rel;

  // The first beat of a frame is evaluated from S_EQ with the live order input.
  assign first_beat = !open_q;
  assign order_msb  = first_beat ? msb_first : msb_q;
  assign cur_state  = first_beat ? S_EQ : state_q;

`ifdef SERIAL_CMP_SIGNED_EN
  // The sign digit arrives first in MSB order and last in LSB order.
  assign is_signed_beat = order_msb ? first_beat : in_last;
`else
  assign is_signed_beat = 1'b0;
`endif

  digit_cmp #(.DIGIT_W(DIGIT_W)) u_digit_cmp (
    .a_dig     (a_dig),
    .b_dig     (b_dig),
    .is_signed (is_signed_beat),
    .rel       (rel)
  );

  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    step_state = cur_state;
    if (order_msb) begin
      if (cur_state == S_EQ) begin
        if (rel == REL_LT)      step_state = S_LT_LK;
        else if (rel == REL_GT) step_state = S_GT_LK;
      end
    end else begin
      // Latest differing digit is the most significant one seen so far.
      if (rel == REL_LT)      step_state = S_LT;
      else if (rel == REL_GT) step_state = S_GT;
    end
  end

  always_comb begin
    state_d     = state_q;
    open_d      = open_q;
    msb_d       = msb_q;
    cnt_d       = cnt_q;
    res_valid_d = 1'b0;
    lt_d        = lt_q;
    eq_d        = eq_q;
    gt_d        = gt_q;
    digits_d    = digits_q;
    if (in_valid) begin
      if (first_beat) msb_d = msb_first;
      if (in_last) begin
        res_valid_d = 1'b1;
        lt_d        = state_is_lt(step_state);
        gt_d        = state_is_gt(step_state);
        eq_d        = (step_state == S_EQ);
        digits_d    = cnt_inc;
        state_d     = S_EQ;
        cnt_d       = '0;
        open_d      = 1'b0;
      end else begin
        state_d = step_state;
        cnt_d   = cnt_inc;
        open_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EQ;
      open_q      <= 1'b0;
      msb_q       <= 1'b1;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b1;
      gt_q        <= 1'b0;
      digits_q    <= '0;
    end else begin
      state_q     <= state_d;
      open_q      <= open_d;
      msb_q       <= msb_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      lt_q        <= lt_d;
      eq_q        <= eq_d;
      gt_q        <= gt_d;
      digits_q    <= digits_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign a_less_b    = lt_q;
  assign a_eq_b      = eq_q;
  assign a_greater_b = gt_q;
  assign res_digits  = digits_q;

endmodule

// File: tb/tb_digit_serial_comparator_fsm.sv
// Bench for digit_serial_comparator_fsm: directed cases plus random frames,
// checked against whole-operand arithmetic comparison of each frame.
module tb_digit_serial_comparator_fsm;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_last, msb_first;
  logic [DW-1:0] a_dig, b_dig;
  logic          res_valid, a_less_b, a_eq_b, a_greater_b;
  logic [7:0]    res_digits;
  logic          s_res_valid, s_less, s_eq, s_greater;
  logic [1:0]    s_res_digits;

  always #5 clk = ~clk;

  digit_serial_comparator_fsm #(.DIGIT_W(DW), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .msb_first(msb_first),
    .a_dig(a_dig), .b_dig(b_dig), .res_valid(res_valid), .a_less_b(a_less_b),
    .a_eq_b(a_eq_b), .a_greater_b(a_greater_b), .res_digits(res_digits)
  );

  digit_serial_comparator_fsm #(.DIGIT_W(DW), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .msb_first(msb_first),
    .a_dig(a_dig), .b_dig(b_dig), .res_valid(s_res_valid), .a_less_b(s_less),
    .a_eq_b(s_eq), .a_greater_b(s_greater), .res_digits(s_res_digits)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_frames = 0;

  // Reference model state: digits of the open frame in arrival order.
  bit            f_open = 0;
  bit            f_msb = 1;
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  bit            exp_lt = 0, exp_eq = 1, exp_gt = 0;
  int            exp_n = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Rebuild both operands as integers and compare them arithmetically.
  function automatic void model_result();
    int n = qa.size();
    logic [63:0] av = '0, bv = '0;
    for (int i = 0; i < n; i++) begin
      int idx = f_msb ? i : n - 1 - i;
      av = (av << DW) | 64'(qa[idx]);
      bv = (bv << DW) | 64'(qb[idx]);
    end
`ifdef SERIAL_CMP_SIGNED_EN
    if (n * DW < 64) begin
      if (av[n*DW-1]) av = av | (~64'd0 << (n * DW));
      if (bv[n*DW-1]) bv = bv | (~64'd0 << (n * DW));
    end
    exp_lt = $signed(av) < $signed(bv);
    exp_gt = $signed(av) > $signed(bv);
`else
    exp_lt = av < bv;
    exp_gt = av > bv;
`endif
    exp_eq = (av == bv);
    exp_n  = n;
  endfunction

  task automatic cycle(input logic v, input logic l, input logic m,
                       input logic [DW-1:0] a, input logic [DW-1:0] b, input logic r);
    bit pend = 0;
    rst = r; in_valid = v; in_last = l; msb_first = m; a_dig = a; b_dig = b;
    if (r) begin
      f_open = 0; qa.delete(); qb.delete();
      exp_lt = 0; exp_eq = 1; exp_gt = 0; exp_n = 0;
    end else if (v) begin
      if (!f_open) begin
        f_open = 1;
        f_msb  = m;
      end
      qa.push_back(a);
      qb.push_back(b);
      if (l) begin
        model_result();
        pend = 1;
        f_open = 0; qa.delete(); qb.delete();
      end
    end
    @(posedge clk);
    #1;
    check("res_valid", 32'(res_valid), 32'(pend));
    check("a_less_b", 32'(a_less_b), 32'(exp_lt));
    check("a_eq_b", 32'(a_eq_b), 32'(exp_eq));
    check("a_greater_b", 32'(a_greater_b), 32'(exp_gt));
    check("res_digits", 32'(res_digits), 32'((exp_n > 255) ? 255 : exp_n));
    check("sat_res_valid", 32'(s_res_valid), 32'(pend));
    check("sat_eq", 32'(s_eq), 32'(exp_eq));
    check("sat_res_digits", 32'(s_res_digits), 32'((exp_n > 3) ? 3 : exp_n));
    if (pend) begin
      n_frames++;
      $display("frame %0d: digits=%0d lt=%0b eq=%0b gt=%0b", n_frames, res_digits,
               a_less_b, a_eq_b, a_greater_b);
    end
  endtask

  // Sends n digits of a and b in the chosen order; optional random gaps and abort by reset.
  task automatic send_frame(input bit m, input logic [63:0] a, input logic [63:0] b,
                            input int n, input int gap_pct, input int abort_at);
    for (int i = 0; i < n; i++) begin
      int idx = m ? n - 1 - i : i;
      logic [63:0] ta = a >> (DW * idx);
      logic [63:0] tb = b >> (DW * idx);
      while ($urandom_range(0, 99) < gap_pct)
        cycle(0, $urandom_range(0, 1), $urandom_range(0, 1), DW'($urandom), DW'($urandom), 0);
      if (i == abort_at) begin
        cycle(0, 0, 0, 0, 0, 1);
        return;
      end
      cycle(1, (i == n - 1), m, ta[DW-1:0], tb[DW-1:0], 0);
    end
  endtask

  initial begin
    cycle(0, 0, 1, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0);

    send_frame(1, 64'h3A, 64'h3C, 2, 0, -1);
    send_frame(0, 64'h52, 64'h43, 2, 0, -1);
    send_frame(1, 64'h52, 64'h43, 2, 0, -1);
    send_frame(0, 64'h3A, 64'h3C, 2, 60, -1);
    send_frame(1, 64'h7, 64'h7, 1, 0, -1);
    send_frame(1, 64'h1, 64'h2, 1, 0, -1);
    cycle(1, 0, 1, 4'h9, 4'h1, 0);
    cycle(0, 0, 0, 0, 0, 1);
    send_frame(1, 64'h0, 64'h0, 1, 0, -1);
    send_frame(0, 64'h12345, 64'h12345, 5, 0, -1);
    send_frame(1, 64'hF0, 64'h10, 2, 0, -1);
    send_frame(0, 64'hF0, 64'h10, 2, 0, -1);
    send_frame(1, 64'h0, 64'h0, 300, 0, -1);

    for (int k = 0; k < 300; k++) begin
      logic [63:0] ra = '0, rb = '0;
      int n = $urandom_range(1, 12);
      bit m = $urandom_range(0, 1);
      int abort_at = ($urandom_range(0, 39) == 0) ? $urandom_range(0, n - 1) : -1;
      for (int d = 0; d < n; d++) begin
        logic [DW-1:0] da = DW'($urandom);
        logic [DW-1:0] db = ($urandom_range(0, 9) < 7) ? da : DW'($urandom);
        ra = ra | (64'(da) << (DW * d));
        rb = rb | (64'(db) << (DW * d));
      end
      send_frame(m, ra, rb, n, 20, abort_at);
      if ($urandom_range(0, 3) == 0) cycle(0, 0, 0, 0, 0, 0);
    end
    cycle(0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
